// File: rtl/aes_bist_engine.sv
// -----------------------------------------------------------------------------
// aes_bist_engine
//
// Built-in self-test engine for the 8-bit AES core. A seeded Galois LFSR
// supplies key/data bytes for N_PATTERNS blocks of BLOCK_BYTES load cycles
// each. Every byte the core returns is compacted into a MISR that uses the
// same polynomial as the LFSR. At the end of the run the MISR is compared
// against GOLDEN_SIG.
//
// Optional feature (define the macro to enable it):
//   BIST_TIMEOUT_EN - a per-block WAIT watchdog. If core_done has not been
//                     seen after TIMEOUT cycles in WAIT, the run ends with
//                     timeout=1 and pass=0. Without the macro there is no
//                     watchdog and timeout is tied low.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   start, abort       start a run (sampled only in IDLE/DONE); cancel a run
//   bist_active, busy  high while a run is in progress (not IDLE/DONE)
//   core_rst           one-cycle reset pulse to the AES core
//   core_key, core_din registered stimulus bytes (zero outside LOAD)
//   core_dout          response byte from the core
//   core_valid         core_dout is valid
//   core_done          the core has finished its block
//   done, pass         run finished / signature matched with no timeout
//   timeout            a block's WAIT phase exceeded TIMEOUT cycles
//   signature          live MISR value
//   pattern_cnt        number of completed blocks
// -----------------------------------------------------------------------------
module aes_bist_engine #(
  parameter int              LANE_W      = 8,
  parameter int              SIG_W       = 32,
  parameter logic [SIG_W-1:0] POLY       = 32'h0040_0007,
  parameter logic [SIG_W-1:0] SEED       = 32'hACE1_5EED,
  parameter int              N_PATTERNS  = 64,
  parameter int              BLOCK_BYTES = 16,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = 32'h0,
  parameter int              TIMEOUT     = 1024,
  localparam int             PCW         = $clog2(N_PATTERNS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              bist_active,
  output logic              core_rst,
  output logic [LANE_W-1:0] core_key,
  output logic [LANE_W-1:0] core_din,
  input  logic [LANE_W-1:0] core_dout,
  input  logic              core_valid,
  input  logic              core_done,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [SIG_W-1:0]  signature,
  output logic [PCW-1:0]    pattern_cnt
);

  localparam int BCW = $clog2(BLOCK_BYTES + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CRST  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]       state;
  logic [SIG_W-1:0] lfsr;
  logic [SIG_W-1:0] misr;
  logic [BCW-1:0]   byte_cnt;

  // One Galois shift; the LFSR uses it directly, the MISR adds the input byte.
  function automatic logic [SIG_W-1:0] galois_step(input logic [SIG_W-1:0] v);
    return {v[SIG_W-2:0], 1'b0} ^ (v[SIG_W-1] ? POLY : '0);
  endfunction

`ifdef BIST_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  logic [TCW-1:0] wait_cnt;
  logic           timeout_hit;
  assign timeout = timeout_hit;
`else
  assign timeout = 1'b0;
`endif

  assign bist_active = (state != S_IDLE) && (state != S_DONE);
  assign busy        = bist_active;
  assign signature   = misr;

  // NOTE: all state in this block uses non-blocking assignments so every
  // right-hand side sees the pre-edge value; blocking here would make the
  // LFSR/MISR updates depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      lfsr        <= SEED;
      misr        <= '0;
      byte_cnt    <= '0;
      pattern_cnt <= '0;
      core_rst    <= 1'b0;
      core_key    <= '0;
      core_din    <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
`ifdef BIST_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_hit <= 1'b0;
`endif
    end else begin
      // NOTE: core_rst defaults low every cycle, so each branch that raises
      // it produces exactly a one-cycle pulse.
      core_rst <= 1'b0;
      if (abort && state != S_IDLE) begin
        // Abort wins over everything; the signature is left for debug.
        state    <= S_IDLE;
        core_rst <= 1'b1;
        core_key <= '0;
        core_din <= '0;
        done     <= 1'b0;
        pass     <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              state       <= S_CRST;
              core_rst    <= 1'b1;
              lfsr        <= SEED;
              misr        <= '0;
              pattern_cnt <= '0;
              done        <= 1'b0;
              pass        <= 1'b0;
`ifdef BIST_TIMEOUT_EN
              timeout_hit <= 1'b0;
`endif
            end
          end
          S_CRST: begin
            // Preload the first byte so it is on the pins in the first LOAD cycle.
            core_key <= lfsr[LANE_W-1:0];
            core_din <= lfsr[2*LANE_W-1:LANE_W];
            lfsr     <= galois_step(lfsr);
            byte_cnt <= '0;
            state    <= S_LOAD;
          end
          S_LOAD: begin
            if (byte_cnt == BCW'(BLOCK_BYTES - 1)) begin
              core_key <= '0;
              core_din <= '0;
              state    <= S_WAIT;
`ifdef BIST_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end else begin
              core_key <= lfsr[LANE_W-1:0];
              core_din <= lfsr[2*LANE_W-1:LANE_W];
              lfsr     <= galois_step(lfsr);
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
          S_WAIT: begin
            if (core_valid)
              misr <= galois_step(misr) ^ SIG_W'(core_dout);
            if (core_done) begin
              pattern_cnt <= pattern_cnt + 1'b1;
              if (pattern_cnt == PCW'(N_PATTERNS - 1)) begin
                state <= S_CHECK;
              end else begin
                // LFSR keeps running across blocks; only start reseeds it.
                state    <= S_CRST;
                core_rst <= 1'b1;
              end
            end
`ifdef BIST_TIMEOUT_EN
            else if (wait_cnt == TCW'(TIMEOUT)) begin
              timeout_hit <= 1'b1;
              state       <= S_CHECK;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
`endif
          end
          S_CHECK: begin
            pass  <= (misr == GOLDEN_SIG) && !timeout;
            done  <= 1'b1;
            state <= S_DONE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_bist_engine.sv
// -----------------------------------------------------------------------------
// tb_aes_bist_engine
//
// Self-checking bench for aes_bist_engine with N_PATTERNS=2 and TIMEOUT=20.
// A behavioural AES-core stand-in answers each block with bytes derived from
// the key/data it expects to have been loaded; the expected signature comes
// from a reference function that walks the LFSR/MISR equations directly.
// Handles both builds (BIST_TIMEOUT_EN defined or not).
// -----------------------------------------------------------------------------
module tb_aes_bist_engine;

  localparam logic [31:0] POLY = 32'h0040_0007;
  localparam logic [31:0] SEED = 32'hACE1_5EED;
  localparam int          NP   = 2;
  localparam int          BB   = 16;
  localparam int          TOUT = 20;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v << 1) ^ (v[31] ? POLY : 32'h0);
  endfunction

  function automatic logic [31:0] misr_next(input logic [31:0] v, input logic [7:0] d);
    return lfsr_next(v) ^ {24'h0, d};
  endfunction

  // Stand-in for the AES core's response to byte idx of a block.
  function automatic logic [7:0] core_f(input logic [7:0] key, input logic [7:0] din, input int idx);
    return (key ^ {din[6:0], din[7]}) + 8'(idx * 3);
  endfunction

  // Signature of a full run; flip_mask is XORed into global byte flip_pos.
  function automatic logic [31:0] ref_signature(input int flip_pos, input logic [7:0] flip_mask);
    logic [31:0] l;
    logic [31:0] m;
    logic [7:0]  d;
    l = SEED;
    m = 32'h0;
    for (int b = 0; b < NP; b++) begin
      for (int i = 0; i < BB; i++) begin
        d = core_f(l[7:0], l[15:8], i);
        if (b * BB + i == flip_pos) d = d ^ flip_mask;
        m = misr_next(m, d);
        l = lfsr_next(l);
      end
    end
    return m;
  endfunction

  localparam logic [31:0] GOLD = ref_signature(-1, 8'h00);

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        bist_active;
  logic        core_rst;
  logic [7:0]  core_key;
  logic [7:0]  core_din;
  logic [7:0]  core_dout;
  logic        core_valid;
  logic        core_done;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [31:0] signature;
  logic [1:0]  pattern_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  aes_bist_engine #(
    .LANE_W(8), .SIG_W(32), .POLY(POLY), .SEED(SEED), .N_PATTERNS(NP),
    .BLOCK_BYTES(BB), .GOLDEN_SIG(GOLD), .TIMEOUT(TOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .bist_active(bist_active), .core_rst(core_rst),
    .core_key(core_key), .core_din(core_din), .core_dout(core_dout),
    .core_valid(core_valid), .core_done(core_done),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .signature(signature), .pattern_cnt(pattern_cnt)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    core_valid = 1'b0; core_done = 1'b0; core_dout = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks++; if (bist_active !== 1'b0) begin n_fail++; $display("FAIL reset_bist_active: got %b want 0", bist_active); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %b want 0", pass); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    n_checks++; if (core_rst !== 1'b0) begin n_fail++; $display("FAIL reset_core_rst: got %b want 0", core_rst); end
    n_checks++; if (signature !== 32'h0) begin n_fail++; $display("FAIL reset_signature: got %h want 0", signature); end
    n_checks++; if (pattern_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_pattern_cnt: got %0d want 0", pattern_cnt); end
    n_checks++; if ({core_key, core_din} !== 16'h0) begin n_fail++; $display("FAIL reset_key_din: got %h want 0", {core_key, core_din}); end
  endtask

  // Full run from a negedge: start pulse, NP blocks, result checks.
  task automatic do_run(input string tag, input int flip_pos, input logic [7:0] flip_mask, input bit noise);
    logic [31:0] l;
    logic [7:0]  kq [BB];
    logic [7:0]  dq [BB];
    logic [31:0] exp_sig;
    logic [7:0]  d;
    bit          exp_pass;
    int          gaps_left;
    exp_sig  = ref_signature(flip_pos, flip_mask);
    exp_pass = (exp_sig == GOLD);
    l = SEED;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < NP; b++) begin
      n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL %s core_rst_pulse blk%0d: got %b want 1", tag, b, core_rst); end
      n_checks++; if (bist_active !== 1'b1) begin n_fail++; $display("FAIL %s bist_active_crst blk%0d: got %b want 1", tag, b, bist_active); end
      for (int i = 0; i < BB; i++) begin
        @(negedge clk);
        if (noise) core_valid = 1'($urandom_range(0, 1));
        kq[i] = l[7:0];
        dq[i] = l[15:8];
        n_checks++; if ({core_key, core_din} !== {kq[i], dq[i]}) begin n_fail++; $display("FAIL %s load_bytes blk%0d byte%0d: got %h want %h", tag, b, i, {core_key, core_din}, {kq[i], dq[i]}); end
        if (i == 0) begin
          n_checks++; if (core_rst !== 1'b0) begin n_fail++; $display("FAIL %s core_rst_width blk%0d: got %b want 0", tag, b, core_rst); end
        end
        l = lfsr_next(l);
      end
      gaps_left = 4;
      for (int i = 0; i < BB; i++) begin
        while (gaps_left > 0 && $urandom_range(0, 1) == 1) begin
          @(negedge clk);
          core_valid = 1'b0; core_done = 1'b0;
          gaps_left--;
        end
        @(negedge clk);
        d = core_f(kq[i], dq[i], i);
        if (b * BB + i == flip_pos) d = d ^ flip_mask;
        core_dout  = d;
        core_valid = 1'b1;
        core_done  = (i == BB - 1);
      end
      @(negedge clk);
      core_valid = 1'b0; core_done = 1'b0;
      n_checks++; if (pattern_cnt !== 2'(b + 1)) begin n_fail++; $display("FAIL %s pattern_cnt blk%0d: got %0d want %0d", tag, b, pattern_cnt, b + 1); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s done_early blk%0d: got %b want 0", tag, b, done); end
    end
    @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL %s done: got %b want 1", tag, done); end
    n_checks++; if (signature !== exp_sig) begin n_fail++; $display("FAIL %s signature: got %h want %h", tag, signature, exp_sig); end
    n_checks++; if (pass !== exp_pass) begin n_fail++; $display("FAIL %s pass: got %b want %b", tag, pass, exp_pass); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_end: got %b want 0", tag, busy); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL %s timeout: got %b want 0", tag, timeout); end
    n_checks++; if (pattern_cnt !== 2'(NP)) begin n_fail++; $display("FAIL %s pattern_cnt_final: got %0d want %0d", tag, pattern_cnt, NP); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_golden_run();
    do_run("golden", -1, 8'h00, 1'b1);
  endtask

  task automatic test_rerun();
    do_run("rerun", -1, 8'h00, 1'b0);
  endtask

  task automatic test_flip();
    do_run("flip", int'($urandom_range(0, NP * BB - 1)), 8'(1 << $urandom_range(0, 7)), 1'b0);
  endtask

  task automatic test_abort();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat ($urandom_range(3, 10)) @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    n_checks++; if (bist_active !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got %b want 0", bist_active); end
    n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL abort_core_rst: got %b want 1", core_rst); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", done); end
    n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL abort_pass: got %b want 0", pass); end
    n_checks++; if (signature !== 32'h0) begin n_fail++; $display("FAIL abort_signature: got %h want 0", signature); end
    n_checks++; if ({core_key, core_din} !== 16'h0) begin n_fail++; $display("FAIL abort_key_din: got %h want 0", {core_key, core_din}); end
    @(negedge clk);
    n_checks++; if (core_rst !== 1'b0) begin n_fail++; $display("FAIL abort_core_rst_width: got %b want 0", core_rst); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_stays_idle: got %b want 0", busy); end
    do_run("after_abort", -1, 8'h00, 1'b1);
  endtask

  task automatic test_timeout();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (BB) @(negedge clk);
`ifdef BIST_TIMEOUT_EN
    // Last LOAD cycle is here; WAIT starts next cycle, result lands 22 later.
    repeat (22) @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL timeout_done_early: got %b want 0", done); end
    n_checks++; if (bist_active !== 1'b1) begin n_fail++; $display("FAIL timeout_active: got %b want 1", bist_active); end
    @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL timeout_done: got %b want 1", done); end
    n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_flag: got %b want 1", timeout); end
    n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL timeout_pass: got %b want 0", pass); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b want 0", busy); end
`else
    repeat (5000) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL no_timeout_busy: got %b want 1", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL no_timeout_done: got %b want 0", done); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL no_timeout_flag: got %b want 0", timeout); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++; if (bist_active !== 1'b0) begin n_fail++; $display("FAIL no_timeout_abort: got %b want 0", bist_active); end
`endif
    @(negedge clk);
    do_run("after_timeout", -1, 8'h00, 1'b1);
  endtask

  initial begin
    test_reset();
    test_golden_run();
    test_rerun();
    test_flip();
    test_abort();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
